// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave: NUM_REGS read/write registers followed by one read-only status word.
// Register 0 bit 0 acts as a start strobe: writing 1 pulses start_pulse and the bit never stores.
module axi_lite_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int NUM_REGS = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_W-1:0]            s_axi_awaddr,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [DATA_W-1:0]            s_axi_wdata,
    input  logic [DATA_W/8-1:0]          s_axi_wstrb,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    input  logic [ADDR_W-1:0]            s_axi_araddr,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [DATA_W-1:0]            s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic                         start_pulse,
    input  logic [DATA_W-1:0]            status_in
);
    localparam int               STRB_W      = DATA_W / 8;
    localparam int               IDX_W       = ADDR_W - 2;
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;
    localparam logic [IDX_W-1:0] STATUS_IDX  = IDX_W'(NUM_REGS);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              r_aw_held;
    logic [IDX_W-1:0]  r_aw_idx;
    logic              r_w_held;
    logic [DATA_W-1:0] r_w_data;
    logic [STRB_W-1:0] r_w_strb;
    logic              r_bvalid;
    logic [1:0]        r_bresp;
    logic              r_start;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;

    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_ar_hs;
    logic              w_commit;
    logic              w_wr_valid;
    logic [IDX_W-1:0]  w_ar_idx;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_rd_err;
    logic              w_unused;

    assign s_axi_awready = !r_aw_held && !r_bvalid;
    assign s_axi_wready  = !r_w_held && !r_bvalid;
    assign s_axi_arready = !r_rvalid;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign start_pulse   = r_start;

    assign w_aw_hs    = s_axi_awvalid && s_axi_awready;
    assign w_w_hs     = s_axi_wvalid && s_axi_wready;
    assign w_ar_hs    = s_axi_arvalid && s_axi_arready;
    assign w_commit   = r_aw_held && r_w_held && !r_bvalid;
    assign w_wr_valid = r_aw_idx < STATUS_IDX;
    assign w_ar_idx   = s_axi_araddr[ADDR_W-1:2];
    assign w_unused   = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[g*DATA_W +: DATA_W] = r_regs[g];
    end

    // Write path: AW and W park independently; the commit consumes both together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the register array is software-visible state, so it is reset like any other flop.
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_aw_held <= 1'b0;
            r_aw_idx  <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_start   <= 1'b0;
        end else begin
            r_start <= 1'b0;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= s_axi_awaddr[ADDR_W-1:2];
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_w_data <= s_axi_wdata;
                r_w_strb <= s_axi_wstrb;
            end
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_valid ? RESP_OKAY : RESP_SLVERR;
                if (w_wr_valid) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (r_aw_idx == IDX_W'(i)) begin
                            for (int b = 0; b < STRB_W; b++) begin
                                if (r_w_strb[b]) r_regs[i][b*8 +: 8] <= r_w_data[b*8 +: 8];
                            end
                        end
                    end
                    r_start <= (r_aw_idx == '0) && r_w_strb[0] && r_w_data[0];
                end
            end else if (r_bvalid && s_axi_bready) begin
                r_bvalid <= 1'b0;
            end
            r_regs[0][0] <= 1'b0;
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        if (w_ar_idx == STATUS_IDX) begin
            w_rd_data = status_in;
        end else if (w_ar_idx > STATUS_IDX) begin
            w_rd_err = 1'b1;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_ar_idx == IDX_W'(i)) w_rd_data = r_regs[i];
            end
        end
    end

    // NOTE: non-blocking updates let a read at the commit edge see the pre-write register value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (r_rvalid && s_axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi_lite_regfile.sv
// Self-checking bench for axi_lite_regfile: directed protocol cases plus randomized
// transactions compared against an array-based register model.
module tb_axi_lite_regfile;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int NREGS  = 10;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [ADDR_W-1:0]         s_axi_awaddr;
    logic                      s_axi_awvalid;
    logic                      s_axi_awready;
    logic [DATA_W-1:0]         s_axi_wdata;
    logic [3:0]                s_axi_wstrb;
    logic                      s_axi_wvalid;
    logic                      s_axi_wready;
    logic [1:0]                s_axi_bresp;
    logic                      s_axi_bvalid;
    logic                      s_axi_bready;
    logic [ADDR_W-1:0]         s_axi_araddr;
    logic                      s_axi_arvalid;
    logic                      s_axi_arready;
    logic [DATA_W-1:0]         s_axi_rdata;
    logic [1:0]                s_axi_rresp;
    logic                      s_axi_rvalid;
    logic                      s_axi_rready;
    logic [NREGS*DATA_W-1:0]   reg_q;
    logic                      start_pulse;
    logic [DATA_W-1:0]         status_in;

    axi_lite_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NREGS)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .reg_q(reg_q), .start_pulse(start_pulse), .status_in(status_in)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] m_regs [NREGS];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: word index above NREGS is invalid, index NREGS is status.
    function automatic logic [1:0] model_write(input logic [5:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        int idx = int'(addr) / 4;
        if (idx >= NREGS) return 2'b10;
        for (int b = 0; b < 4; b++)
            if (strb[b]) m_regs[idx][8*b +: 8] = data[8*b +: 8];
        if (idx == 0) m_regs[0][0] = 1'b0;
        return 2'b00;
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < NREGS; i++)
            check($sformatf("%s reg_q[%0d]", tag, i), 64'(reg_q[i*32 +: 32]), 64'(m_regs[i]));
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_delay, input int w_delay, input int b_stall);
        int   cyc = 0;
        bit   aw_done = 0, w_done = 0, aw_hs, w_hs;
        logic [1:0] exp_resp;
        bit   exp_pulse;
        s_axi_awaddr = addr;
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        while (!(aw_done && w_done)) begin
            s_axi_awvalid = !aw_done && (cyc >= aw_delay);
            s_axi_wvalid  = !w_done && (cyc >= w_delay);
            if (w_done) check("awready while W held", 64'(s_axi_awready), 64'd1);
            if (aw_done) check("wready while AW held", 64'(s_axi_wready), 64'd1);
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            step();
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            cyc++;
            if (cyc > 40) begin
                check("write handshake timeout", 64'd0, 64'd1);
                break;
            end
        end
        s_axi_awvalid = 0;
        s_axi_wvalid  = 0;
        check("bvalid before commit edge", 64'(s_axi_bvalid), 64'd0);
        step();
        exp_pulse = (int'(addr) / 4 == 0) && strb[0] && data[0];
        exp_resp  = model_write(addr, data, strb);
        check("bvalid latency", 64'(s_axi_bvalid), 64'd1);
        check("bresp", 64'(s_axi_bresp), 64'(exp_resp));
        check("start_pulse at commit", 64'(start_pulse), 64'(exp_pulse));
        for (int s = 0; s < b_stall; s++) begin
            check("awready low during B stall", 64'(s_axi_awready), 64'd0);
            check("wready low during B stall", 64'(s_axi_wready), 64'd0);
            step();
            check("bvalid stable", 64'(s_axi_bvalid), 64'd1);
            check("bresp stable", 64'(s_axi_bresp), 64'(exp_resp));
            check("start_pulse one cycle", 64'(start_pulse), 64'd0);
        end
        s_axi_bready = 1;
        step();
        s_axi_bready = 0;
        check("bvalid cleared", 64'(s_axi_bvalid), 64'd0);
        check("start_pulse cleared", 64'(start_pulse), 64'd0);
        check_regs("after write");
    endtask

    task automatic do_read(input logic [5:0] addr, input int r_stall);
        int   idx = int'(addr) / 4;
        int   cyc = 0;
        bit   hs = 0;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        exp_data = (idx < NREGS) ? m_regs[idx] : (idx == NREGS) ? status_in : 32'd0;
        exp_resp = (idx > NREGS) ? 2'b10 : 2'b00;
        s_axi_araddr = addr;
        while (!hs) begin
            s_axi_arvalid = 1;
            hs = s_axi_arready;
            step();
            cyc++;
            if (cyc > 40) begin
                check("read handshake timeout", 64'd0, 64'd1);
                break;
            end
        end
        s_axi_arvalid = 0;
        check("rvalid", 64'(s_axi_rvalid), 64'd1);
        check($sformatf("rdata idx %0d", idx), 64'(s_axi_rdata), 64'(exp_data));
        check("rresp", 64'(s_axi_rresp), 64'(exp_resp));
        check("arready low while R pending", 64'(s_axi_arready), 64'd0);
        for (int s = 0; s < r_stall; s++) begin
            status_in = $urandom;
            step();
            check("rvalid stable", 64'(s_axi_rvalid), 64'd1);
            check("rdata stable", 64'(s_axi_rdata), 64'(exp_data));
            check("rresp stable", 64'(s_axi_rresp), 64'(exp_resp));
        end
        s_axi_rready = 1;
        step();
        s_axi_rready = 0;
        check("rvalid cleared", 64'(s_axi_rvalid), 64'd0);
        check("arready restored", 64'(s_axi_arready), 64'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " awready"}, 64'(s_axi_awready), 64'd1);
        check({tag, " wready"}, 64'(s_axi_wready), 64'd1);
        check({tag, " arready"}, 64'(s_axi_arready), 64'd1);
        check({tag, " bvalid"}, 64'(s_axi_bvalid), 64'd0);
        check({tag, " rvalid"}, 64'(s_axi_rvalid), 64'd0);
        check({tag, " start_pulse"}, 64'(start_pulse), 64'd0);
        check({tag, " bresp"}, 64'(s_axi_bresp), 64'd0);
        check({tag, " rresp"}, 64'(s_axi_rresp), 64'd0);
        check({tag, " rdata"}, 64'(s_axi_rdata), 64'd0);
    endtask

    task automatic apply_reset();
        rst_n = 0;
        step();
        rst_n = 1;
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    endtask

    initial begin
        logic [31:0] old_val;
        rst_n = 0;
        s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = 0; s_axi_bready = 0; s_axi_araddr = '0; s_axi_arvalid = 0;
        s_axi_rready = 0; status_in = '0;
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        repeat (3) step();
        rst_n = 1;
        check_idle("reset");
        check_regs("reset");

        // Basic write/read, then W leading AW by three cycles with partial strobes.
        do_write(6'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_read(6'h04, 0);
        do_write(6'h08, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        do_write(6'h08, 32'h1234ABCD, 4'h3, 3, 0, 0);
        check("reg2 partial strobe", 64'(reg_q[2*32 +: 32]), 64'h0000_0000_FFFF_ABCD);
        do_read(6'h08, 0);

        // Start strobe on reg 0 bit 0.
        do_write(6'h00, 32'h0000_0001, 4'hF, 0, 0, 0);
        do_read(6'h00, 0);

        // Status and invalid indices.
        status_in = 32'h0000_00A5;
        do_write(6'h28, 32'h1111_1111, 4'hF, 0, 0, 0);
        do_write(6'h3C, 32'h2222_2222, 4'hF, 1, 0, 0);
        do_read(6'h3C, 0);
        status_in = 32'h0000_00A5;
        do_read(6'h28, 0);

        // Backpressure on B and R.
        do_write(6'h0C, 32'hCAFE_F00D, 4'hF, 0, 2, 5);
        do_read(6'h0C, 5);

        // Read handshake on the same edge as a commit to the same register.
        old_val = m_regs[3];
        s_axi_awaddr = 6'h0C; s_axi_wdata = 32'h55AA_55AA; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        step();
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        s_axi_araddr = 6'h0C; s_axi_arvalid = 1;
        step();
        s_axi_arvalid = 0;
        check("same-edge commit bvalid", 64'(s_axi_bvalid), 64'd1);
        check("same-edge read old value", 64'(s_axi_rdata), 64'(old_val));
        void'(model_write(6'h0C, 32'h55AA_55AA, 4'hF));
        s_axi_bready = 1; s_axi_rready = 1;
        step();
        s_axi_bready = 0; s_axi_rready = 0;
        check("same-edge bvalid cleared", 64'(s_axi_bvalid), 64'd0);
        check_regs("same-edge");

        // Reset with W held and R pending: nothing commits afterwards.
        s_axi_wdata = 32'h7777_7777; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
        step();
        s_axi_wvalid = 0;
        check("W held before reset", 64'(s_axi_wready), 64'd0);
        s_axi_araddr = 6'h04; s_axi_arvalid = 1;
        step();
        s_axi_arvalid = 0;
        check("R pending before reset", 64'(s_axi_rvalid), 64'd1);
        apply_reset();
        check_idle("mid-op reset");
        check_regs("mid-op reset");
        s_axi_awaddr = 6'h04; s_axi_awvalid = 1;
        step();
        s_axi_awvalid = 0;
        repeat (2) step();
        check("no commit of discarded W", 64'(s_axi_bvalid), 64'd0);
        check_regs("no commit of discarded W");
        apply_reset();

        // Randomized traffic against the model.
        for (int t = 0; t < 120; t++) begin
            logic [5:0] a;
            a = {4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            end else begin
                status_in = $urandom;
                do_read(a, int'($urandom_range(0, 2)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
